// File: rtl/shift_rx_deser.sv
// shift_rx_deser: serial-in / parallel-out receiver for an LSB-first
// strobed serial stream. Rebuilds WIDTH-bit words, starting each word on a
// bit qualified by frame, and presents them on a valid/ready handshake.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   - one extra even-parity bit follows each word; par_err is
//               loaded with dout.
//   undefined - completion on bit WIDTH; par_err tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   sin        serial data bit (sampled when sin_en=1)
//   sin_en     bit strobe
//   frame      start-of-word marker, qualified by sin_en
//   ready      consumer accepts dout when valid=1
//   clr_err    synchronous clear of sticky overrun/frame_err
//   dout       received word, LSB = first bit received
//   valid      dout holds an unconsumed word
//   overrun    sticky: a completed word was dropped
//   frame_err  sticky: frame arrived mid-word, partial word discarded
//   par_err    parity mismatch for the current dout word
module shift_rx_deser #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame,
    input  logic             ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             overrun,
    output logic             frame_err,
    output logic             par_err
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t             r_state, w_state_nx;
    logic [WIDTH-1:0]   r_sr, w_sr_nx, w_sr_shift, w_word;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic               w_done, w_ferr_set;
    logic [WIDTH-1:0]   r_dout;
    logic               r_valid, r_overrun, r_frame_err;
`ifdef PARITY_CHECK_EN
    logic               w_par;
    logic               r_par_err;
`endif

    // LSB-first: new bit enters at the top, oldest bit ends up in bit 0.
    assign w_sr_shift = {sin, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sr    <= w_sr_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sr_nx    = r_sr;
        w_cnt_nx   = r_cnt;
        w_done     = 1'b0;
        w_word     = w_sr_shift;
        w_ferr_set = 1'b0;
`ifdef PARITY_CHECK_EN
        w_par      = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                // Unframed strobes in IDLE are line noise and are dropped.
                if (sin_en && frame) begin
                    w_sr_nx    = w_sr_shift;
                    w_cnt_nx   = CNT_W'(1);
                    w_state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_en) begin
                    w_sr_nx = w_sr_shift;
                    if (frame) begin
                        // Resync: this bit becomes bit 0 of a fresh word.
                        w_ferr_set = 1'b1;
                        w_cnt_nx   = CNT_W'(1);
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(WIDTH-1)) begin
`ifdef PARITY_CHECK_EN
                            w_state_nx = PARITY;
`else
                            w_done     = 1'b1;
                            w_state_nx = IDLE;
`endif
                        end
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (sin_en) begin
                    if (frame) begin
                        w_ferr_set = 1'b1;
                        w_sr_nx    = w_sr_shift;
                        w_cnt_nx   = CNT_W'(1);
                        w_state_nx = SHIFT;
                    end else begin
                        // Even parity: XOR over data and parity bit is 0.
                        w_done     = 1'b1;
                        w_word     = r_sr;
                        w_par      = (^r_sr) ^ sin;
                        w_state_nx = IDLE;
                    end
                end
            end
`endif
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            // A held, unaccepted word wins over a newly completed one.
            if (w_done && !(r_valid && !ready)) begin
                r_dout  <= w_word;
                r_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                r_par_err <= w_par;
`endif
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (w_done && r_valid && !ready) r_overrun <= 1'b1;
            else if (clr_err)                r_overrun <= 1'b0;

            if (w_ferr_set)   r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
        end
    end

    assign dout      = r_dout;
    assign valid     = r_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
`ifdef PARITY_CHECK_EN
    assign par_err   = r_par_err;
`else
    assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rx_deser.sv
// Testbench for shift_rx_deser: directed scenarios plus random traffic,
// checked by a queue-based reference model and a decoupled monitor.
module tb_shift_rx_deser;
    localparam int WIDTH = 4;
`ifdef PARITY_CHECK_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic clk, reset_n, sin, sin_en, frame, ready, clr_err;
    logic [WIDTH-1:0] dout;
    logic valid, overrun, frame_err, par_err;

    shift_rx_deser #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .sin(sin), .sin_en(sin_en),
        .frame(frame), .ready(ready), .clr_err(clr_err), .dout(dout),
        .valid(valid), .overrun(overrun), .frame_err(frame_err),
        .par_err(par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [WIDTH-1:0] word; logic par; } exp_t;
    exp_t sb[$];
    int   cur[$];          // bits of the word being received, in order
    bit   mvalid, mover, mferr;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        cur.delete(); sb.delete();
        mvalid = 0; mover = 0; mferr = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs the DUT
    // sees on this edge.
    task automatic model_step();
        bit set_o, set_f, done;
        exp_t e;
        if (!reset_n) begin model_clear(); return; end
        set_o = 0; set_f = 0; done = 0;
        e.word = '0; e.par = 1'b0;
        if (sin_en) begin
            if (frame) begin
                if (cur.size() > 0) set_f = 1;
                cur.delete();
                cur.push_back(int'(sin));
            end else if (cur.size() > 0) begin
                cur.push_back(int'(sin));
            end
            if (cur.size() == NB) begin
                done = 1;
                for (int i = 0; i < WIDTH; i++) e.word[i] = cur[i][0];
`ifdef PARITY_CHECK_EN
                for (int i = 0; i < NB; i++) e.par = e.par ^ cur[i][0];
`endif
                cur.delete();
            end
        end
        if (done) begin
            if (mvalid && !ready) set_o = 1;
            else begin sb.push_back(e); mvalid = 1; end
        end else if (mvalid && ready) begin
            mvalid = 0;
        end
        mover = set_o ? 1'b1 : (clr_err ? 1'b0 : mover);
        mferr = set_f ? 1'b1 : (clr_err ? 1'b0 : mferr);
    endtask

    task automatic cyc(input logic s, input logic e, input logic f, input logic r, input logic c);
        @(posedge clk);
        model_step();
        #1;
        sin = s; sin_en = e; frame = f; ready = r; clr_err = c;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic r, input logic pflip);
        for (int i = 0; i < WIDTH; i++) cyc(w[i], 1'b1, i == 0, r, 1'b0);
`ifdef PARITY_CHECK_EN
        cyc((^w) ^ pflip, 1'b1, 1'b0, r, 1'b0);
`else
        if (pflip) cyc(1'b0, 1'b0, 1'b0, r, 1'b0);
`endif
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_dout"}, 32'(dout), 32'(0));
        chk({tag, "_valid"}, 32'(valid), 32'(0));
        chk({tag, "_overrun"}, 32'(overrun), 32'(0));
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(0));
        chk({tag, "_par_err"}, 32'(par_err), 32'(0));
    endtask

    // Monitor: flags every cycle, words popped from the scoreboard on transfer.
    always @(negedge clk) begin
        exp_t e;
        chk("valid", 32'(valid), 32'(mvalid));
        chk("overrun", 32'(overrun), 32'(mover));
        chk("frame_err", 32'(frame_err), 32'(mferr));
        if (reset_n && valid && ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty actual=transfer expected=no_word at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("sb_dout", 32'(dout), 32'(e.word));
                chk("sb_par_err", 32'(par_err), 32'(e.par));
            end
        end
    end

    initial begin
        reset_n = 0; sin = 0; sin_en = 0; frame = 0; ready = 0; clr_err = 0;
        model_clear();
        #3;
        chk_reset_outs("por");
        repeat (2) cyc(0, 0, 0, 0, 0);
        @(posedge clk); model_step(); #1; reset_n = 1;

        // 1: single word 1,0,1,1 -> 4'b1101, valid for one cycle
        cyc(1, 1, 1, 1, 0); cyc(0, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0);
`ifdef PARITY_CHECK_EN
        cyc(1, 1, 0, 1, 0);
`endif
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t1_valid", 32'(valid), 32'(1));
        chk("t1_dout", 32'(dout), 32'(4'b1101));
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t1_valid_drop", 32'(valid), 32'(0));

        // 2: backpressure and overrun
        send_word(4'hA, 1'b0, 1'b0);
        cyc(0, 0, 0, 0, 0);
        send_word(4'h5, 1'b0, 1'b0);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_dout_held", 32'(dout), 32'(4'hA));
        chk("t2_overrun", 32'(overrun), 32'(1));
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_valid_drop", 32'(valid), 32'(0));
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_overrun_clr", 32'(overrun), 32'(0));

        // 3: resync mid-word
        cyc(1, 1, 1, 1, 0); cyc(1, 1, 0, 1, 0);
        send_word(4'h4, 1'b1, 1'b0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t3_dout", 32'(dout), 32'(4'h4));
        chk("t3_frame_err", 32'(frame_err), 32'(1));
        cyc(0, 0, 0, 1, 1);

        // 4: idle noise then back-to-back words
        cyc(1, 1, 0, 1, 0); cyc(0, 1, 0, 1, 0); cyc(1, 1, 0, 1, 0);
        send_word(4'h3, 1'b1, 1'b0);
        send_word(4'hC, 1'b1, 1'b0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t4_dout2", 32'(dout), 32'(4'hC));
        cyc(0, 0, 0, 1, 0);

        // 5: reset mid-word
        cyc(1, 1, 1, 1, 0); cyc(0, 1, 0, 1, 0);
        @(posedge clk); model_step(); #1;
        reset_n = 0; sin_en = 0; frame = 0;
        model_clear();
        #2;
        chk_reset_outs("t5_rst");
        cyc(0, 0, 0, 1, 0);
        @(posedge clk); model_step(); #1; reset_n = 1;
        send_word(4'h9, 1'b1, 1'b0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t5_dout", 32'(dout), 32'(4'h9));
        chk("t5_frame_err", 32'(frame_err), 32'(0));

`ifdef PARITY_CHECK_EN
        // 6: parity good / bad
        send_word(4'h7, 1'b1, 1'b0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t6_par_ok", 32'(par_err), 32'(0));
        send_word(4'h7, 1'b1, 1'b1);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("t6_par_bad", 32'(par_err), 32'(1));
        chk("t6_valid", 32'(valid), 32'(1));
`endif

        // random framed words with random backpressure
        for (int n = 0; n < 60; n++) begin
            send_word(WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) cyc(0, 0, 0, 1, 1'($urandom_range(0, 1)));
        end
        // fully random line activity
        for (int n = 0; n < 2000; n++) begin
            logic e, f;
            e = ($urandom_range(0, 3) != 0);
            f = e && ($urandom_range(0, 7) == 0);
            cyc(1'($urandom_range(0, 1)), e, f, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0));
        end
        repeat (4) cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
